// File: rtl/vga_timing_pkg.sv
// Shared raster mode constants so the timing generator and pixel streamer agree
// on visible geometry.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_visible;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_mode_t MODE_800X600_40M = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_mode_t MODE_DEFAULT     = MODE_640X480_60;

  localparam int unsigned DEFAULT_CNT_W = 11;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and a
// look-ahead active flag / wrap pulse for the parent to combine.
module vga_axis_counter #(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter bit          POL     = 1'b0,
  parameter int unsigned W       = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap_c,
  output logic         active_c,
  output logic         sync
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;

  // One extra bit so a sync window ending exactly at 2^W still compares correctly.
  localparam logic [W:0]   VIS_E    = (W+1)'(VISIBLE);
  localparam logic [W:0]   SYNC_BEG = (W+1)'(VISIBLE + FRONT);
  localparam logic [W:0]   SYNC_END = (W+1)'(VISIBLE + FRONT + SYNC);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

  logic [W-1:0] count_nxt;
  logic [W:0]   count_ext;
  logic         sync_on;

  always_comb begin
    wrap_c    = 1'b0;
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (tick) begin
      wrap_c    = (count == LAST);
      count_nxt = wrap_c ? '0 : count + W'(1);
    end
    count_ext = {1'b0, count_nxt};
    active_c  = !clear && (count_ext < VIS_E);
    sync_on   = !clear && (count_ext >= SYNC_BEG) && (count_ext < SYNC_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sync  <= !POL;
    end else begin
      count <= count_nxt;
      sync  <= sync_on ? POL : !POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: x/y position, syncs, visible-area gate and
// line/frame start strobes, advanced by a pixel-rate enable.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = MODE_DEFAULT.h_visible,
  parameter int unsigned H_FRONT   = MODE_DEFAULT.h_front,
  parameter int unsigned H_SYNC    = MODE_DEFAULT.h_sync,
  parameter int unsigned H_BACK    = MODE_DEFAULT.h_back,
  parameter int unsigned V_VISIBLE = MODE_DEFAULT.v_visible,
  parameter int unsigned V_FRONT   = MODE_DEFAULT.v_front,
  parameter int unsigned V_SYNC    = MODE_DEFAULT.v_sync,
  parameter int unsigned V_BACK    = MODE_DEFAULT.v_back,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_pixEn,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_pixGate,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_lineStart,
  output logic             o_frameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (64'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_h_total_too_wide
    $error("vga_timing: H_TOTAL does not fit in CNT_W bits");
  end
  if (64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_v_total_too_wide
    $error("vga_timing: V_TOTAL does not fit in CNT_W bits");
  end

  logic clear;
  logic h_wrap_c;
  logic h_active_c;
  logic v_wrap_c;
  logic v_active_c;

  assign clear = !i_enable;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .W       (CNT_W)
  ) u_h (
    .clk      (i_clk),
    .rst      (i_reset),
    .tick     (i_pixEn),
    .clear    (clear),
    .count    (o_x),
    .wrap_c   (h_wrap_c),
    .active_c (h_active_c),
    .sync     (o_hsync)
  );

  // Vertical axis steps once per completed line.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .W       (CNT_W)
  ) u_v (
    .clk      (i_clk),
    .rst      (i_reset),
    .tick     (h_wrap_c),
    .clear    (clear),
    .count    (o_y),
    .wrap_c   (v_wrap_c),
    .active_c (v_active_c),
    .sync     (o_vsync)
  );

  // Strobes fire only on a real wrap, so enable edges and stalls never produce them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pixGate    <= 1'b0;
      o_lineStart  <= 1'b0;
      o_frameStart <= 1'b0;
    end else begin
      o_pixGate    <= h_active_c && v_active_c;
      o_lineStart  <= h_wrap_c;
      o_frameStart <= h_wrap_c && v_wrap_c;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Randomized scoreboard bench for vga_timing on a reduced raster, with an
// arithmetic reference model of the position/sync/strobe rules.
module tb_vga_timing;

  localparam int HV = 20, HF = 3, HSW = 5, HB = 4;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int CW = 5;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          gate;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
  } obs_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_pixEn = 1'b0;
  logic          o_hsync, o_vsync, o_pixGate, o_lineStart, o_frameStart;
  logic [CW-1:0] o_x, o_y;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  int   mx = 0, my = 0;
  bit   stim_done = 1'b0;

  always #5 i_clk = ~i_clk;

  vga_timing #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .CNT_W (CW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_pixEn      (i_pixEn),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_pixGate    (o_pixGate),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_lineStart  (o_lineStart),
    .o_frameStart (o_frameStart)
  );

  // Reference: expected outputs after the coming edge, pushed to the scoreboard.
  task automatic model(input bit en, input bit pe, input bit rst);
    obs_t e;
    e = '0;
    if (rst || !en) begin
      mx = 0;
      my = 0;
      e.hs = !HPOL;
      e.vs = !VPOL;
    end else begin
      if (pe) begin
        mx = (mx + 1) % HT;
        if (mx == 0) begin
          my = (my + 1) % VT;
          e.ls = 1'b1;
          e.fs = (my == 0);
        end
      end
      e.gate = (mx < HV) && (my < VV);
      e.hs = (mx >= HV + HF && mx < HV + HF + HSW) ? HPOL : !HPOL;
      e.vs = (my >= VV + VF && my < VV + VF + VSW) ? VPOL : !VPOL;
    end
    e.x = CW'(mx);
    e.y = CW'(my);
    sb.push_back(e);
  endtask

  task automatic drive(input bit en, input bit pe, input bit rst);
    @(negedge i_clk);
    #1;
    i_reset  = rst;
    i_enable = en;
    i_pixEn  = pe;
    model(en, pe, rst);
  endtask

  task automatic run_to(input int tx, input int ty);
    int guard;
    guard = 0;
    while (!(mx == tx && my == ty) && guard < 2 * HT * VT) begin
      drive(1'b1, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (!(mx == tx && my == ty)) begin
      errors++;
      $display("FAIL run_to position (%0d,%0d) never reached, got (%0d,%0d)", tx, ty, mx, my);
    end
  endtask

  // Monitor: each entry pushed before an edge is checked on the following falling edge.
  initial begin
    obs_t e, got;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = '{o_x, o_y, o_pixGate, o_hsync, o_vsync, o_lineStart, o_frameStart};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs got x=%0d y=%0d gate=%b hs=%b vs=%b ls=%b fs=%b expected x=%0d y=%0d gate=%b hs=%b vs=%b ls=%b fs=%b",
                   got.x, got.y, got.gate, got.hs, got.vs, got.ls, got.fs,
                   e.x, e.y, e.gate, e.hs, e.vs, e.ls, e.fs);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'(i), 1'b0);
    // Enable with pixEn low: origin held, no strobe.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    // Continuous pixels over two full frames and a bit.
    for (int i = 0; i < 2 * HT * VT + 40; i++) drive(1'b1, 1'b1, 1'b0);
    // Pixel enable every fourth cycle.
    for (int i = 0; i < 8 * HT; i++) drive(1'b1, 1'((i % 4) == 3), 1'b0);
    // Random pixel enable with occasional enable drops.
    for (int i = 0; i < 1500; i++)
      drive(1'(($urandom % 150) != 0), 1'($urandom % 2), 1'b0);
    // Drop enable mid-frame, then resume from origin.
    run_to(10, 5);
    drive(1'b0, 1'($urandom % 2), 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * HT; i++) drive(1'b1, 1'b1, 1'b0);
    // Asynchronous reset in the middle of hsync.
    run_to(HV + HF + 2, 3);
    @(negedge i_clk);
    #1;
    checks++;
    if (o_hsync !== HPOL) begin
      errors++;
      $display("FAIL pre_reset_hsync got %b expected %b", o_hsync, HPOL);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_x !== '0 || o_y !== '0 || o_hsync !== !HPOL || o_vsync !== !VPOL || o_pixGate !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b gate=%b expected x=0 y=0 hs=%b vs=%b gate=0",
               o_x, o_y, o_hsync, o_vsync, o_pixGate, !HPOL, !VPOL);
    end
    model(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < HT * VT + 10; i++) drive(1'b1, 1'b1, 1'b0);
    stim_done = 1'b1;
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge i_clk);
      wait_cyc++;
    end
    @(posedge i_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
